// File: rtl/id_pkg.sv
// Decode-stage shared types: decode bundle, opcode/funct constants, operation and
// instruction-type encodings. EX imports the same package.
package id_pkg;

   localparam int XLEN   = 32;
   localparam int RIDX_W = 5;

   localparam logic [5:0] OPC_SPEC   = 6'h00;
   localparam logic [5:0] OPC_REGIMM = 6'h01;
   localparam logic [5:0] OPC_J      = 6'h02;
   localparam logic [5:0] OPC_JAL    = 6'h03;
   localparam logic [5:0] OPC_BEQ    = 6'h04;
   localparam logic [5:0] OPC_BNE    = 6'h05;
   localparam logic [5:0] OPC_BLEZ   = 6'h06;
   localparam logic [5:0] OPC_BGTZ   = 6'h07;
   localparam logic [5:0] OPC_ADDI   = 6'h08;
   localparam logic [5:0] OPC_ADDIU  = 6'h09;
   localparam logic [5:0] OPC_SLTI   = 6'h0A;
   localparam logic [5:0] OPC_SLTIU  = 6'h0B;
   localparam logic [5:0] OPC_ANDI   = 6'h0C;
   localparam logic [5:0] OPC_ORI    = 6'h0D;
   localparam logic [5:0] OPC_XORI   = 6'h0E;
   localparam logic [5:0] OPC_LUI    = 6'h0F;
   localparam logic [5:0] OPC_LW     = 6'h23;
   localparam logic [5:0] OPC_SW     = 6'h2B;

   localparam logic [5:0] FN_SLL     = 6'h00;
   localparam logic [5:0] FN_SRL     = 6'h02;
   localparam logic [5:0] FN_SRA     = 6'h03;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;
   localparam logic [5:0] FN_BREAK   = 6'h0D;
   localparam logic [5:0] FN_ADD     = 6'h20;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUB     = 6'h22;
   localparam logic [5:0] FN_SUBU    = 6'h23;
   localparam logic [5:0] FN_AND     = 6'h24;
   localparam logic [5:0] FN_OR      = 6'h25;
   localparam logic [5:0] FN_XOR     = 6'h26;
   localparam logic [5:0] FN_NOR     = 6'h27;
   localparam logic [5:0] FN_SLT     = 6'h2A;
   localparam logic [5:0] FN_SLTU    = 6'h2B;

   localparam logic [4:0] RT_BLTZ    = 5'd0;
   localparam logic [4:0] RT_BGEZ    = 5'd1;
   localparam logic [4:0] REG_LINK   = 5'd31;

   typedef enum logic [2:0] {
      ITYP_NONE = 3'd0,
      ITYP_R    = 3'd1,
      ITYP_I    = 3'd2,
      ITYP_M    = 3'd3,
      ITYP_B    = 3'd4,
      ITYP_J    = 3'd5,
      ITYP_SYS  = 3'd6
   } ityp_t;

   typedef enum logic [4:0] {
      OPER_NOP  = 5'd0,  OPER_ADD = 5'd1,  OPER_ADDU = 5'd2,  OPER_SUB = 5'd3,
      OPER_SUBU = 5'd4,  OPER_AND = 5'd5,  OPER_OR   = 5'd6,  OPER_XOR = 5'd7,
      OPER_NOR  = 5'd8,  OPER_SLT = 5'd9,  OPER_SLTU = 5'd10, OPER_SLL = 5'd11,
      OPER_SRL  = 5'd12, OPER_SRA = 5'd13, OPER_LUI  = 5'd14, OPER_LW  = 5'd15,
      OPER_SW   = 5'd16, OPER_BR  = 5'd17, OPER_JMP  = 5'd18, OPER_JAL = 5'd19
   } oper_t;

   typedef enum logic [3:0] {
      BR_NONE = 4'd0, BR_EQ  = 4'd1, BR_NE  = 4'd2, BR_LEZ = 4'd3, BR_GTZ = 4'd4,
      BR_LTZ  = 4'd5, BR_GEZ = 4'd6, BR_J   = 4'd7, BR_JR  = 4'd8
   } br_t;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      ityp_t             ityp;
      oper_t             oper;
      logic [5:0]        func;
      logic [15:0]       imme;
      logic [RIDX_W-1:0] rs_regf;
      logic [RIDX_W-1:0] rt_regf;
      logic [RIDX_W-1:0] rd_regf;
      logic [XLEN-1:0]   srca;
      logic [XLEN-1:0]   srcb;
      logic              sy;
      logic              bp;
      logic              ri;
      logic              er;
   } dec_t;

   // Word offset of a conditional branch, sign-extended to the datapath.
   function automatic logic [XLEN-1:0] br_offset(input logic [15:0] imme);
      return {{(XLEN-18){imme[15]}}, imme, 2'b00};
   endfunction

endpackage

// File: rtl/id_stage_decode.sv
// Combinational instruction decoder: classifies the word, extracts register fields,
// reports which sources are read and the branch kind; operands are filled in by id_stage.
module id_stage_decode
   import id_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] inst,
   output dec_t            dec,
   output br_t             br,
   output logic            use_rs,
   output logic            use_rt
);

   logic [5:0] opc_s;
   logic [5:0] fn_s;

   assign opc_s = inst[31:26];
   assign fn_s  = inst[5:0];

   // opcode / funct classification
   always_comb begin
      dec         = '0;
      dec.pc      = pc;
      dec.func    = fn_s;
      dec.imme    = inst[15:0];
      dec.rs_regf = inst[25:21];
      dec.rt_regf = inst[20:16];
      dec.er      = (pc[1:0] != 2'b00);
      br          = BR_NONE;
      use_rs      = 1'b0;
      use_rt      = 1'b0;
      case (opc_s)
         OPC_SPEC: begin
            dec.ityp    = ITYP_R;
            dec.rd_regf = inst[15:11];
            use_rs      = 1'b1;
            use_rt      = 1'b1;
            case (fn_s)
               FN_SLL:  begin dec.oper = OPER_SLL; use_rs = 1'b0; end
               FN_SRL:  begin dec.oper = OPER_SRL; use_rs = 1'b0; end
               FN_SRA:  begin dec.oper = OPER_SRA; use_rs = 1'b0; end
               FN_JR:   begin dec.ityp = ITYP_J; dec.oper = OPER_JMP; dec.rd_regf = 5'd0;
                              use_rt = 1'b0; br = BR_JR; end
               FN_JALR: begin dec.ityp = ITYP_J; dec.oper = OPER_JAL; use_rt = 1'b0; br = BR_JR; end
               FN_SYSCALL: begin dec.ityp = ITYP_SYS; dec.sy = 1'b1; dec.rd_regf = 5'd0;
                                 use_rs = 1'b0; use_rt = 1'b0; end
               FN_BREAK: begin dec.ityp = ITYP_SYS; dec.bp = 1'b1; dec.rd_regf = 5'd0;
                               use_rs = 1'b0; use_rt = 1'b0; end
               FN_ADD:  dec.oper = OPER_ADD;
               FN_ADDU: dec.oper = OPER_ADDU;
               FN_SUB:  dec.oper = OPER_SUB;
               FN_SUBU: dec.oper = OPER_SUBU;
               FN_AND:  dec.oper = OPER_AND;
               FN_OR:   dec.oper = OPER_OR;
               FN_XOR:  dec.oper = OPER_XOR;
               FN_NOR:  dec.oper = OPER_NOR;
               FN_SLT:  dec.oper = OPER_SLT;
               FN_SLTU: dec.oper = OPER_SLTU;
               default: begin dec.ityp = ITYP_NONE; dec.ri = 1'b1; dec.rd_regf = 5'd0;
                              use_rs = 1'b0; use_rt = 1'b0; end
            endcase
         end
         OPC_REGIMM: begin
            dec.ityp = ITYP_B;
            dec.oper = OPER_BR;
            use_rs   = 1'b1;
            case (inst[20:16])
               RT_BLTZ: br = BR_LTZ;
               RT_BGEZ: br = BR_GEZ;
               default: begin dec.ityp = ITYP_NONE; dec.oper = OPER_NOP; dec.ri = 1'b1;
                              use_rs = 1'b0; end
            endcase
         end
         OPC_J:    begin dec.ityp = ITYP_J; dec.oper = OPER_JMP; br = BR_J; end
         OPC_JAL:  begin dec.ityp = ITYP_J; dec.oper = OPER_JAL; dec.rd_regf = REG_LINK; br = BR_J; end
         OPC_BEQ:  begin dec.ityp = ITYP_B; dec.oper = OPER_BR; use_rs = 1'b1; use_rt = 1'b1; br = BR_EQ; end
         OPC_BNE:  begin dec.ityp = ITYP_B; dec.oper = OPER_BR; use_rs = 1'b1; use_rt = 1'b1; br = BR_NE; end
         OPC_BLEZ: begin dec.ityp = ITYP_B; dec.oper = OPER_BR; use_rs = 1'b1; br = BR_LEZ; end
         OPC_BGTZ: begin dec.ityp = ITYP_B; dec.oper = OPER_BR; use_rs = 1'b1; br = BR_GTZ; end
         OPC_ADDI:  begin dec.ityp = ITYP_I; dec.oper = OPER_ADD;  dec.rd_regf = inst[20:16]; use_rs = 1'b1; end
         OPC_ADDIU: begin dec.ityp = ITYP_I; dec.oper = OPER_ADDU; dec.rd_regf = inst[20:16]; use_rs = 1'b1; end
         OPC_SLTI:  begin dec.ityp = ITYP_I; dec.oper = OPER_SLT;  dec.rd_regf = inst[20:16]; use_rs = 1'b1; end
         OPC_SLTIU: begin dec.ityp = ITYP_I; dec.oper = OPER_SLTU; dec.rd_regf = inst[20:16]; use_rs = 1'b1; end
         OPC_ANDI:  begin dec.ityp = ITYP_I; dec.oper = OPER_AND;  dec.rd_regf = inst[20:16]; use_rs = 1'b1; end
         OPC_ORI:   begin dec.ityp = ITYP_I; dec.oper = OPER_OR;   dec.rd_regf = inst[20:16]; use_rs = 1'b1; end
         OPC_XORI:  begin dec.ityp = ITYP_I; dec.oper = OPER_XOR;  dec.rd_regf = inst[20:16]; use_rs = 1'b1; end
         OPC_LUI:   begin dec.ityp = ITYP_I; dec.oper = OPER_LUI;  dec.rd_regf = inst[20:16]; end
         OPC_LW:    begin dec.ityp = ITYP_M; dec.oper = OPER_LW;   dec.rd_regf = inst[20:16]; use_rs = 1'b1; end
         OPC_SW:    begin dec.ityp = ITYP_M; dec.oper = OPER_SW;   use_rs = 1'b1; use_rt = 1'b1; end
         default:   begin dec.ityp = ITYP_NONE; dec.ri = 1'b1; end
      endcase
   end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: operand forwarding, load-use stall, branch resolution
// and the registered valid/ready handshake toward EX.
module id_stage
   import id_pkg::*;
#(
   parameter int DATA_W = XLEN,
   parameter int REGF_N = 32,
   parameter int FWD_N  = 3,
   localparam int REGF_W = $clog2(REGF_N)
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_pc,
   input  logic [DATA_W-1:0]            in_inst,
   input  logic [DATA_W-1:0]            rs_data,
   input  logic [DATA_W-1:0]            rt_data,
   input  logic [FWD_N-1:0]             fwd_valid,
   input  logic [FWD_N-1:0]             fwd_pending,
   input  logic [FWD_N-1:0][REGF_W-1:0] fwd_regf,
   input  logic [FWD_N-1:0][DATA_W-1:0] fwd_data,
   input  logic                         flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output dec_t                         out_dec,
   output logic                         branch,
   output logic [DATA_W-1:0]            branch_addr,
   output logic [15:0]                  stall_cnt
);

   dec_t              dec_s;
   dec_t              dec_next_s;
   br_t               br_s;
   logic              use_rs_s;
   logic              use_rt_s;
   logic [DATA_W-1:0] fwd_a_s;
   logic [DATA_W-1:0] fwd_b_s;
   logic [DATA_W-1:0] srca_s;
   logic [DATA_W-1:0] srcb_s;
   logic              dep_s;
   logic              hazard_s;
   logic              accept_s;
   logic              cond_s;
   logic              taken_s;
   logic [DATA_W-1:0] pc4_s;
   logic [DATA_W-1:0] target_s;

   id_stage_decode u_decode (
      .pc     (in_pc),
      .inst   (in_inst),
      .dec    (dec_s),
      .br     (br_s),
      .use_rs (use_rs_s),
      .use_rt (use_rt_s)
   );

   // forwarding mux (lowest index wins) and pending-producer dependency
   always_comb begin
      fwd_a_s = rs_data;
      fwd_b_s = rt_data;
      dep_s   = 1'b0;
      for (int i = FWD_N - 1; i >= 0; i--) begin
         fwd_a_s = (fwd_valid[i] && !fwd_pending[i] && (fwd_regf[i] == dec_s.rs_regf))
                   ? fwd_data[i] : fwd_a_s;
         fwd_b_s = (fwd_valid[i] && !fwd_pending[i] && (fwd_regf[i] == dec_s.rt_regf))
                   ? fwd_data[i] : fwd_b_s;
         dep_s   = dep_s | (fwd_valid[i] && fwd_pending[i] && (fwd_regf[i] != {REGF_W{1'b0}}) &&
                            ((use_rs_s && (fwd_regf[i] == dec_s.rs_regf)) ||
                             (use_rt_s && (fwd_regf[i] == dec_s.rt_regf))));
      end
      srca_s = (dec_s.rs_regf == 5'd0) ? {DATA_W{1'b0}} : fwd_a_s;
      srcb_s = (dec_s.rt_regf == 5'd0) ? {DATA_W{1'b0}} : fwd_b_s;
   end

   assign hazard_s = in_valid && dep_s;
   assign in_ready = (!out_valid || out_ready) && !hazard_s && !flush;
   assign accept_s = in_valid && in_ready;
   assign pc4_s    = in_pc + 32'd4;

   // branch condition and redirect target
   always_comb begin
      case (br_s)
         BR_EQ:   cond_s = (srca_s == srcb_s);
         BR_NE:   cond_s = (srca_s != srcb_s);
         BR_LEZ:  cond_s = srca_s[DATA_W-1] || (srca_s == {DATA_W{1'b0}});
         BR_GTZ:  cond_s = !srca_s[DATA_W-1] && (srca_s != {DATA_W{1'b0}});
         BR_LTZ:  cond_s = srca_s[DATA_W-1];
         BR_GEZ:  cond_s = !srca_s[DATA_W-1];
         BR_J:    cond_s = 1'b1;
         BR_JR:   cond_s = 1'b1;
         default: cond_s = 1'b0;
      endcase
      case (br_s)
         BR_J:    target_s = {pc4_s[DATA_W-1:28], in_inst[25:0], 2'b00};
         BR_JR:   target_s = srca_s;
         default: target_s = pc4_s + br_offset(dec_s.imme);
      endcase
      taken_s = cond_s && !dec_s.ri && !dec_s.er;
   end

   // decoded bundle with resolved operands
   always_comb begin
      dec_next_s      = dec_s;
      dec_next_s.srca = srca_s;
      dec_next_s.srcb = srcb_s;
   end

   // output register, handshake and one-cycle branch pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_dec     <= '0;
         branch      <= 1'b0;
         branch_addr <= {DATA_W{1'b0}};
      end else if (flush) begin
         out_valid   <= 1'b0;
         branch      <= 1'b0;
         branch_addr <= {DATA_W{1'b0}};
      end else if (accept_s) begin
         out_valid   <= 1'b1;
         out_dec     <= dec_next_s;
         branch      <= taken_s;
         branch_addr <= taken_s ? target_s : {DATA_W{1'b0}};
      end else begin
         out_valid   <= out_valid && !out_ready;
         branch      <= 1'b0;
         branch_addr <= {DATA_W{1'b0}};
      end
   end

   // saturating hazard-stall counter
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= 16'd0;
      end else if (hazard_s && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end else begin
         stall_cnt <= stall_cnt;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by random traffic,
// compared against an instruction-kind level reference model.
module tb_id_stage;
   import id_pkg::*;

   localparam int DW = 32;
   localparam int RN = 32;
   localparam int FN = 3;

   localparam int K_ADD = 0, K_ADDI = 1, K_LUI = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5,
                  K_BLEZ = 6, K_BGTZ = 7, K_BLTZ = 8, K_BGEZ = 9, K_J = 10, K_JAL = 11,
                  K_JR = 12, K_JALR = 13, K_SYS = 14, K_BRK = 15, K_BAD = 16;

   logic                   clk = 1'b0;
   logic                   rst, in_valid, in_ready, flush, out_valid, out_ready, branch;
   logic [DW-1:0]          in_pc, in_inst, rs_data, rt_data, branch_addr;
   logic [FN-1:0]          fwd_valid, fwd_pending;
   logic [FN-1:0][4:0]     fwd_regf;
   logic [FN-1:0][DW-1:0]  fwd_data;
   dec_t                   out_dec;
   logic [15:0]            stall_cnt;

   always #5 clk = ~clk;

   id_stage #(.DATA_W(DW), .REGF_N(RN), .FWD_N(FN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_inst(in_inst), .rs_data(rs_data), .rt_data(rt_data), .fwd_valid(fwd_valid),
      .fwd_pending(fwd_pending), .fwd_regf(fwd_regf), .fwd_data(fwd_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_dec(out_dec), .branch(branch),
      .branch_addr(branch_addr), .stall_cnt(stall_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cur_kind;

   // reference model state
   logic        m_valid, m_branch;
   logic [31:0] m_pc, m_srca, m_srcb, m_addr;
   logic [4:0]  m_rs, m_rt;
   logic [3:0]  m_flags;
   int          m_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got=%08h want=%08h", tag, got, want);
      end
   endtask

   function automatic bit uses_rs(input int k);
      return k inside {K_ADD, K_ADDI, K_SW, K_BEQ, K_BNE, K_BLEZ, K_BGTZ, K_BLTZ, K_BGEZ, K_JR, K_JALR};
   endfunction

   function automatic bit uses_rt(input int k);
      return k inside {K_ADD, K_SW, K_BEQ, K_BNE};
   endfunction

   function automatic logic [31:0] opval(input logic [4:0] r, input logic [31:0] rf);
      if (r == 5'd0) return 32'd0;
      for (int i = 0; i < FN; i++)
         if (fwd_valid[i] && !fwd_pending[i] && fwd_regf[i] == r) return fwd_data[i];
      return rf;
   endfunction

   function automatic bit taken(input int k, input logic [31:0] a, input logic [31:0] b);
      case (k)
         K_BEQ:  return a == b;
         K_BNE:  return a != b;
         K_BLEZ: return $signed(a) <= 0;
         K_BGTZ: return $signed(a) > 0;
         K_BLTZ: return $signed(a) < 0;
         K_BGEZ: return $signed(a) >= 0;
         K_J, K_JAL, K_JR, K_JALR: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] target(input int k, input logic [31:0] pc,
                                          input logic [31:0] inst, input logic [31:0] a);
      int s;
      s = $signed(inst[15:0]);
      case (k)
         K_J, K_JAL:   return ((pc + 32'd4) & 32'hF000_0000) | (32'(inst[25:0]) << 2);
         K_JR, K_JALR: return a;
         default:      return pc + 32'd4 + 32'(s * 4);
      endcase
   endfunction

   task automatic set_inst(input int k, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [15:0] imm, input logic [25:0] idx);
      cur_kind = k;
      case (k)
         K_ADD:  in_inst = {6'h00, rs, rt, 5'd3, 5'd0, 6'h20};
         K_ADDI: in_inst = {6'h08, rs, rt, imm};
         K_LUI:  in_inst = {6'h0F, 5'd0, rt, imm};
         K_SW:   in_inst = {6'h2B, rs, rt, imm};
         K_BEQ:  in_inst = {6'h04, rs, rt, imm};
         K_BNE:  in_inst = {6'h05, rs, rt, imm};
         K_BLEZ: in_inst = {6'h06, rs, 5'd0, imm};
         K_BGTZ: in_inst = {6'h07, rs, 5'd0, imm};
         K_BLTZ: in_inst = {6'h01, rs, 5'd0, imm};
         K_BGEZ: in_inst = {6'h01, rs, 5'd1, imm};
         K_J:    in_inst = {6'h02, idx};
         K_JAL:  in_inst = {6'h03, idx};
         K_JR:   in_inst = {6'h00, rs, 15'd0, 6'h08};
         K_JALR: in_inst = {6'h00, rs, 5'd0, 5'd31, 5'd0, 6'h09};
         K_SYS:  in_inst = {6'h00, 20'd0, 6'h0C};
         K_BRK:  in_inst = {6'h00, 20'd0, 6'h0D};
         default: in_inst = {6'h3F, idx};
      endcase
   endtask

   task automatic quiet();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_pc = 32'h0000_1000; rs_data = 32'd0; rt_data = 32'd0;
      fwd_valid = '0; fwd_pending = '0; fwd_regf = '0; fwd_data = '0;
      set_inst(K_ADD, 5'd1, 5'd2, 16'd0, 26'd0);
   endtask

   // one clock: model update from current inputs, then compare registered outputs
   task automatic cycle();
      logic [4:0]  ra, rb;
      logic [31:0] va, vb;
      bit          haz, rdy, tk, was_rst;
      @(negedge clk);
      ra = in_inst[25:21];
      rb = in_inst[20:16];
      haz = 1'b0;
      for (int i = 0; i < FN; i++)
         if (fwd_valid[i] && fwd_pending[i] && fwd_regf[i] != 5'd0 &&
             ((uses_rs(cur_kind) && fwd_regf[i] == ra) || (uses_rt(cur_kind) && fwd_regf[i] == rb)))
            haz = 1'b1;
      haz = haz && in_valid;
      rdy = (!m_valid || out_ready) && !haz && !flush;
      if (!rst) check_eq("in_ready", 32'(in_ready), 32'(rdy));
      va = opval(ra, rs_data);
      vb = opval(rb, rt_data);
      was_rst = rst;
      if (rst) begin
         m_valid = 1'b0; m_branch = 1'b0; m_addr = 32'd0; m_cnt = 0;
      end else begin
         if (haz && m_cnt < 65535) m_cnt++;
         if (flush) begin
            m_valid = 1'b0; m_branch = 1'b0; m_addr = 32'd0;
         end else if (in_valid && rdy) begin
            m_valid = 1'b1; m_pc = in_pc; m_srca = va; m_srcb = vb; m_rs = ra; m_rt = rb;
            m_flags = {cur_kind == K_SYS, cur_kind == K_BRK, cur_kind == K_BAD, in_pc[1:0] != 2'b00};
            tk = taken(cur_kind, va, vb) && (in_pc[1:0] == 2'b00);
            m_branch = tk;
            m_addr = tk ? target(cur_kind, in_pc, in_inst, va) : 32'd0;
         end else begin
            if (out_ready) m_valid = 1'b0;
            m_branch = 1'b0; m_addr = 32'd0;
         end
      end
      @(posedge clk);
      #1;
      check_eq("out_valid", 32'(out_valid), 32'(m_valid));
      check_eq("branch", 32'(branch), 32'(m_branch));
      check_eq("branch_addr", branch_addr, m_addr);
      check_eq("stall_cnt", 32'(stall_cnt), m_cnt);
      if (was_rst) check_eq("reset_dec_zero", 32'(out_dec !== '0), 32'd0);
      if (m_valid) begin
         check_eq("dec_pc", out_dec.pc, m_pc);
         check_eq("dec_srca", out_dec.srca, m_srca);
         check_eq("dec_srcb", out_dec.srcb, m_srcb);
         check_eq("dec_rs", 32'(out_dec.rs_regf), 32'(m_rs));
         check_eq("dec_rt", 32'(out_dec.rt_regf), 32'(m_rt));
         check_eq("dec_flags", 32'({out_dec.sy, out_dec.bp, out_dec.ri, out_dec.er}), 32'(m_flags));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m_valid = 1'b0; m_branch = 1'b0; m_addr = 32'd0; m_cnt = 0;
      m_pc = 32'd0; m_srca = 32'd0; m_srcb = 32'd0; m_rs = 5'd0; m_rt = 5'd0; m_flags = 4'd0;
      quiet();
      rst = 1'b1;
      cycle(); cycle();
      rst = 1'b0;
      cycle();

      // taken BEQ
      in_valid = 1'b1; in_pc = 32'h100; rs_data = 32'h55; rt_data = 32'h55;
      set_inst(K_BEQ, 5'd5, 5'd5, 16'h0004, 26'd0);
      cycle();
      check_eq("beq_branch", 32'(branch), 32'd1);
      check_eq("beq_addr", branch_addr, 32'h114);
      check_eq("beq_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      cycle();

      // load-use stall on rs=8
      fwd_valid = 3'b001; fwd_pending = 3'b001; fwd_regf[0] = 5'd8;
      in_valid = 1'b1; in_pc = 32'h200; set_inst(K_ADD, 5'd8, 5'd2, 16'd0, 26'd0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_eq("stall_ready", 32'(in_ready), 32'd0);
      end
      check_eq("stall_cnt3", 32'(stall_cnt), 32'd3);
      fwd_pending = 3'b000; fwd_data[0] = 32'h8888;
      cycle();
      check_eq("stall_accept_srca", out_dec.srca, 32'h8888);

      // forwarding priority and register 0
      fwd_valid = 3'b101; fwd_pending = 3'b000; fwd_regf[0] = 5'd9; fwd_regf[2] = 5'd9;
      fwd_data[0] = 32'hAAAA; fwd_data[2] = 32'hBBBB; in_pc = 32'h208;
      set_inst(K_ADDI, 5'd9, 5'd4, 16'h0001, 26'd0);
      cycle();
      check_eq("fwd_prio", out_dec.srca, 32'hAAAA);
      fwd_regf[0] = 5'd0; fwd_regf[2] = 5'd0; fwd_data[0] = 32'h1234; rs_data = 32'h5555;
      in_pc = 32'h20C; set_inst(K_ADDI, 5'd0, 5'd4, 16'h0001, 26'd0);
      cycle();
      check_eq("fwd_reg0", out_dec.srca, 32'd0);

      // backpressure: held bundle stays, nothing lost or duplicated
      fwd_valid = '0; out_ready = 1'b0; in_pc = 32'h300;
      set_inst(K_ADD, 5'd1, 5'd2, 16'd0, 26'd0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check_eq("bp_hold_pc", out_dec.pc, 32'h20C);
         check_eq("bp_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      cycle();
      check_eq("bp_release_pc", out_dec.pc, 32'h300);
      in_valid = 1'b0;
      cycle();

      // flush against a taken JR
      in_valid = 1'b1; flush = 1'b1; rs_data = 32'h4000; in_pc = 32'h310;
      set_inst(K_JR, 5'd3, 5'd0, 16'd0, 26'd0);
      cycle();
      check_eq("flush_valid", 32'(out_valid), 32'd0);
      check_eq("flush_branch", 32'(branch), 32'd0);
      flush = 1'b0; in_valid = 1'b0;
      cycle();

      // reset while holding and stalled
      in_valid = 1'b1; out_ready = 1'b0; in_pc = 32'h400;
      set_inst(K_ADD, 5'd6, 5'd2, 16'd0, 26'd0);
      cycle();
      fwd_valid = 3'b010; fwd_pending = 3'b010; fwd_regf[1] = 5'd6;
      for (int i = 0; i < 4; i++) cycle();
      check_eq("pre_rst_cnt", 32'(stall_cnt), 32'd7);
      check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      cycle();
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_cnt", 32'(stall_cnt), 32'd0);
      check_eq("rst_branch", 32'(branch), 32'd0);
      quiet();
      cycle();

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] pc;
         rst       = ($urandom_range(0, 63) == 0);
         flush     = ($urandom_range(0, 11) == 0);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         pc = $urandom();
         if ($urandom_range(0, 15) != 0) pc[1:0] = 2'b00;
         in_pc   = pc;
         rs_data = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
         rt_data = ($urandom_range(0, 1) == 0) ? rs_data : $urandom();
         for (int i = 0; i < FN; i++) begin
            fwd_valid[i]   = 1'($urandom_range(0, 1));
            fwd_pending[i] = ($urandom_range(0, 3) == 0);
            fwd_regf[i]    = 5'($urandom_range(0, 7));
            fwd_data[i]    = $urandom();
         end
         set_inst($urandom_range(0, 16), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  16'($urandom()), 26'($urandom()));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
